// File: rtl/rpn_stack_ctrl_if.sv
// Command/status bundle for rpn_stack_ctrl.
// Latency: none; this file holds wires only.
// Backpressure: cmd_ready, which rpn_stack_ctrl drives from its FSM.
interface rpn_stack_ctrl_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic [7:0] dIn;
  logic [7:0] dOut;
  logic       dValid;
  logic [5:0] GPO;
  logic [3:0] debug;
  logic [3:0] sp;

  modport master (
    output cmd_valid, cmd, dIn,
    input  cmd_ready, dOut, dValid, GPO, debug, sp
  );

  modport slave (
    input  cmd_valid, cmd, dIn,
    output cmd_ready, dOut, dValid, GPO, debug, sp
  );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// RPN stack engine: 8-bit operand stack driven by opcodes over a valid/ready port.
// Latency: PUSH/POP/DUP/CLEAR/NOP finish on the accepting edge; ADD/SUB take 3 cycles, SWAP 4.
// Backpressure: cmd_ready is low while a multi-cycle op runs; commands offered then are dropped.
// Build option: define SATURATE_EN for signed saturating ADD/SUB (otherwise results wrap).
module rpn_stack_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic           clock,
  input  logic           reset,
  rpn_stack_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POPB  = 3'd1,
    POPA  = 3'd2,
    EXEC  = 3'd3,
    PUSH2 = 3'd4
  } state_t;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;
  localparam logic [3:0] DEPTH_L  = 4'(DEPTH);

  state_t     state, state_nxt;
  logic [3:0] sp, sp_nxt;
  logic [7:0] a, a_nxt, b, b_nxt;
  logic [2:0] op, op_nxt;
  logic [5:0] gpo, gpo_nxt;
  logic [7:0] dout;
  logic       dvalid;

  // 16 slots so any 4-bit index is in range; only the low DEPTH are ever written.
  logic [7:0] mem [0:15];
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [7:0] wr_dat;

  logic [7:0] top, res, top_nxt;
  logic [3:0] top_idx;
  logic [8:0] sum9, diff9;
  logic       carry, sat;

  assign top           = mem[sp - 4'd1];
  assign bus.cmd_ready = (state == IDLE);
  assign bus.debug     = {1'b0, state};
  assign bus.sp        = sp;
  assign bus.dOut      = dout;
  assign bus.dValid    = dvalid;
  assign bus.GPO       = gpo;

  // ALU: A op B with unsigned carry/borrow, optional signed clamp.
  always_comb begin
    sum9  = {1'b0, a} + {1'b0, b};
    diff9 = {1'b0, a} - {1'b0, b};
    res   = (op == OP_SUB) ? diff9[7:0] : sum9[7:0];
    carry = (op == OP_SUB) ? diff9[8] : sum9[8];
    sat   = 1'b0;
`ifdef SATURATE_EN
    if (op == OP_SUB) sat = (a[7] != b[7]) && (diff9[7] != a[7]);
    else              sat = (a[7] == b[7]) && (sum9[7] != a[7]);
    if (sat) res = a[7] ? 8'h80 : 8'h7F;
`endif
  end

  // Next-state, stack write and flag update; underflow/overflow are rejected at acceptance.
  always_comb begin
    state_nxt = state;
    sp_nxt    = sp;
    a_nxt     = a;
    b_nxt     = b;
    op_nxt    = op;
    gpo_nxt   = gpo;
    wr_en     = 1'b0;
    wr_idx    = sp;
    wr_dat    = 8'h00;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            OP_PUSH: begin
              if (sp == DEPTH_L) gpo_nxt[4] = 1'b1;
              else begin
                wr_en  = 1'b1;
                wr_dat = bus.dIn;
                sp_nxt = sp + 4'd1;
              end
            end
            OP_POP: begin
              if (sp == 4'd0) gpo_nxt[5] = 1'b1;
              else            sp_nxt = sp - 4'd1;
            end
            OP_DUP: begin
              if (sp == 4'd0)         gpo_nxt[5] = 1'b1;
              else if (sp == DEPTH_L) gpo_nxt[4] = 1'b1;
              else begin
                wr_en  = 1'b1;
                wr_dat = top;
                sp_nxt = sp + 4'd1;
              end
            end
            OP_CLEAR: begin
              sp_nxt  = 4'd0;
              gpo_nxt = 6'd0;
            end
            OP_ADD, OP_SUB, OP_SWAP: begin
              if (sp < 4'd2) gpo_nxt[5] = 1'b1;
              else begin
                op_nxt    = bus.cmd;
                state_nxt = POPB;
              end
            end
            default: ;
          endcase
        end
      end
      POPB: begin
        b_nxt     = top;
        sp_nxt    = sp - 4'd1;
        state_nxt = POPA;
      end
      POPA: begin
        a_nxt     = top;
        sp_nxt    = sp - 4'd1;
        state_nxt = EXEC;
      end
      EXEC: begin
        wr_en  = 1'b1;
        sp_nxt = sp + 4'd1;
        if (op == OP_SWAP) begin
          wr_dat    = b;
          state_nxt = PUSH2;
        end else begin
          wr_dat     = res;
          gpo_nxt[0] = (res == 8'h00);
          gpo_nxt[1] = res[7];
          gpo_nxt[2] = carry;
          gpo_nxt[3] = sat;
          state_nxt  = IDLE;
        end
      end
      PUSH2: begin
        wr_en     = 1'b1;
        wr_dat    = a;
        sp_nxt    = sp + 4'd1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Top-of-stack after this cycle, forwarding the entry being written.
  always_comb begin
    top_idx = sp_nxt - 4'd1;
    top_nxt = (wr_en && (wr_idx == top_idx)) ? wr_dat : mem[top_idx];
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp     <= 4'd0;
      a      <= 8'h00;
      b      <= 8'h00;
      op     <= OP_NOP;
      gpo    <= 6'd0;
      dout   <= 8'h00;
      dvalid <= 1'b0;
    end else begin
      sp     <= sp_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      op     <= op_nxt;
      gpo    <= gpo_nxt;
      dout   <= (sp_nxt == 4'd0) ? 8'h00 : top_nxt;
      dvalid <= (sp_nxt != 4'd0);
    end
  end

  // Stack storage; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: directed vector table, hand-written corner sequences,
// then random commands against a queue-based model of the stack.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_rpn_stack_ctrl;
  localparam int DEPTH = 8;
  localparam logic [2:0] C_PUSH = 3'd0, C_POP = 3'd1, C_ADD = 3'd2, C_SUB = 3'd3,
                         C_DUP = 3'd4, C_SWAP = 3'd5, C_CLEAR = 3'd6, C_NOP = 3'd7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  rpn_stack_ctrl_if bus();

  rpn_stack_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Reference model: the stack as a queue (back = top) plus the flag byte.
  logic [7:0] stk[$];
  logic [5:0] m_gpo;

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] sp;
    logic [5:0] gpo;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, got, exp);
    end
  endtask

  function automatic void model_apply(input logic [2:0] c, input logic [7:0] d);
    logic [7:0] a, b, r;
    int s, sa, sb, t;
    logic cy, st;
    case (c)
      C_PUSH: if (stk.size() == DEPTH) m_gpo[4] = 1'b1; else stk.push_back(d);
      C_POP:  if (stk.size() == 0) m_gpo[5] = 1'b1; else void'(stk.pop_back());
      C_DUP: begin
        if (stk.size() == 0)          m_gpo[5] = 1'b1;
        else if (stk.size() == DEPTH) m_gpo[4] = 1'b1;
        else stk.push_back(stk[stk.size()-1]);
      end
      C_CLEAR: begin stk.delete(); m_gpo = 6'd0; end
      C_NOP: ;
      C_SWAP: begin
        if (stk.size() < 2) m_gpo[5] = 1'b1;
        else begin
          b = stk.pop_back(); a = stk.pop_back();
          stk.push_back(b); stk.push_back(a);
        end
      end
      default: begin
        if (stk.size() < 2) m_gpo[5] = 1'b1;
        else begin
          b = stk.pop_back(); a = stk.pop_back();
          if (c == C_ADD) begin s = int'(a) + int'(b); cy = (s > 255); end
          else            begin s = int'(a) - int'(b); cy = (s < 0);   end
          r  = s[7:0];
          st = 1'b0;
          sa = 0; sb = 0; t = 0;
`ifdef SATURATE_EN
          sa = a[7] ? int'(a) - 256 : int'(a);
          sb = b[7] ? int'(b) - 256 : int'(b);
          t  = (c == C_ADD) ? sa + sb : sa - sb;
          if (t > 127)       begin r = 8'h7F; st = 1'b1; end
          else if (t < -128) begin r = 8'h80; st = 1'b1; end
`endif
          m_gpo[0] = (r == 8'h00);
          m_gpo[1] = r[7];
          m_gpo[2] = cy;
          m_gpo[3] = st;
          stk.push_back(r);
        end
      end
    endcase
  endfunction

  task automatic check_state(input string tag);
    logic [7:0] et;
    et = (stk.size() == 0) ? 8'h00 : stk[stk.size()-1];
    chk({tag, ".dOut"},   32'(bus.dOut),      32'(et));
    chk({tag, ".dValid"}, 32'(bus.dValid),    32'(stk.size() != 0));
    chk({tag, ".sp"},     32'(bus.sp),        32'(stk.size()));
    chk({tag, ".GPO"},    32'(bus.GPO),       32'(m_gpo));
    chk({tag, ".ready"},  32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (!bus.cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.timeout: actual ready=0 required ready=1 within 10 cycles", tag);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d);
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.dIn       = d;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    wait_ready("issue");
    model_apply(c, d);
  endtask

  initial begin
    int busy;
    logic [2:0] c;
    logic [7:0] d;
    logic [3:0] exp_dbg [0:3];
    logic [3:0] exp_sp  [0:3];
    logic       exp_rdy [0:3];
    exp_dbg = '{4'd1, 4'd2, 4'd3, 4'd0};
    exp_sp  = '{4'd2, 4'd1, 4'd0, 4'd1};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};

    vt.push_back('{C_PUSH,  8'h05, 8'h05, 4'd1, 6'h00});
    vt.push_back('{C_PUSH,  8'h03, 8'h03, 4'd2, 6'h00});
    vt.push_back('{C_SUB,   8'h00, 8'h02, 4'd1, 6'h00});
    vt.push_back('{C_CLEAR, 8'h00, 8'h00, 4'd0, 6'h00});
    vt.push_back('{C_PUSH,  8'h03, 8'h03, 4'd1, 6'h00});
    vt.push_back('{C_PUSH,  8'h05, 8'h05, 4'd2, 6'h00});
    vt.push_back('{C_SUB,   8'h00, 8'hFE, 4'd1, 6'h06});
    vt.push_back('{C_CLEAR, 8'h00, 8'h00, 4'd0, 6'h00});
    vt.push_back('{C_PUSH,  8'h7F, 8'h7F, 4'd1, 6'h00});
    vt.push_back('{C_PUSH,  8'h01, 8'h01, 4'd2, 6'h00});
`ifdef SATURATE_EN
    vt.push_back('{C_ADD,   8'h00, 8'h7F, 4'd1, 6'h08});
    vt.push_back('{C_POP,   8'h00, 8'h00, 4'd0, 6'h08});
    vt.push_back('{C_POP,   8'h00, 8'h00, 4'd0, 6'h28});
`else
    vt.push_back('{C_ADD,   8'h00, 8'h80, 4'd1, 6'h02});
    vt.push_back('{C_POP,   8'h00, 8'h00, 4'd0, 6'h02});
    vt.push_back('{C_POP,   8'h00, 8'h00, 4'd0, 6'h22});
`endif
    vt.push_back('{C_CLEAR, 8'h00, 8'h00, 4'd0, 6'h00});
    vt.push_back('{C_PUSH,  8'h0A, 8'h0A, 4'd1, 6'h00});
    vt.push_back('{C_PUSH,  8'h0B, 8'h0B, 4'd2, 6'h00});
    vt.push_back('{C_SWAP,  8'h00, 8'h0A, 4'd2, 6'h00});
    vt.push_back('{C_POP,   8'h00, 8'h0B, 4'd1, 6'h00});
    vt.push_back('{C_DUP,   8'h00, 8'h0B, 4'd2, 6'h00});
    vt.push_back('{C_ADD,   8'h00, 8'h16, 4'd1, 6'h00});
    vt.push_back('{C_SUB,   8'h00, 8'h16, 4'd1, 6'h20});
    vt.push_back('{C_PUSH,  8'hFF, 8'hFF, 4'd2, 6'h20});
    vt.push_back('{C_PUSH,  8'h01, 8'h01, 4'd3, 6'h20});
    vt.push_back('{C_ADD,   8'h00, 8'h00, 4'd2, 6'h25});
    vt.push_back('{C_NOP,   8'h00, 8'h00, 4'd2, 6'h25});
    vt.push_back('{C_DUP,   8'h00, 8'h00, 4'd3, 6'h25});
    vt.push_back('{C_CLEAR, 8'h00, 8'h00, 4'd0, 6'h00});

    bus.cmd_valid = 1'b0;
    bus.cmd       = C_NOP;
    bus.dIn       = 8'h00;
    m_gpo         = 6'd0;

    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst.dOut",  32'(bus.dOut),  32'h0);
    chk("rst.debug", 32'(bus.debug), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check_state("rst");
    chk("rst.debug2", 32'(bus.debug), 32'h0);

    // Directed vector table.
    foreach (vt[i]) begin
      issue(vt[i].cmd, vt[i].din);
      chk($sformatf("vec%0d.dOut", i),   32'(bus.dOut),      32'(vt[i].dout));
      chk($sformatf("vec%0d.sp", i),     32'(bus.sp),        32'(vt[i].sp));
      chk($sformatf("vec%0d.dValid", i), 32'(bus.dValid),    32'(vt[i].sp != 4'd0));
      chk($sformatf("vec%0d.GPO", i),    32'(bus.GPO),       32'(vt[i].gpo));
      chk($sformatf("vec%0d.ready", i),  32'(bus.cmd_ready), 32'd1);
    end

    // SUB walks POPB/POPA/EXEC with the intermediate depth visible.
    issue(C_PUSH, 8'h05);
    issue(C_PUSH, 8'h03);
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_SUB;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("subseq%0d.debug", i), 32'(bus.debug),     32'(exp_dbg[i]));
      chk($sformatf("subseq%0d.sp", i),    32'(bus.sp),        32'(exp_sp[i]));
      chk($sformatf("subseq%0d.ready", i), 32'(bus.cmd_ready), 32'(exp_rdy[i]));
      if (i < 3) @(negedge clock);
    end
    model_apply(C_SUB, 8'h00);
    check_state("subseq");
    issue(C_CLEAR, 8'h00);

    // Overflow on the extra PUSH, then underflow on ADD after CLEAR.
    for (int i = 0; i <= DEPTH; i++) issue(C_PUSH, 8'(i + 1));
    check_state("ovf");
    chk("ovf.GPO4", 32'(bus.GPO[4]), 32'd1);
    chk("ovf.sp",   32'(bus.sp),     32'(DEPTH));
    issue(C_CLEAR, 8'h00);
    issue(C_ADD, 8'h00);
    check_state("unf");
    chk("unf.GPO5", 32'(bus.GPO[5]), 32'd1);
    chk("unf.sp",   32'(bus.sp),     32'd0);
    issue(C_CLEAR, 8'h00);

    // SWAP with cmd_valid held high through the busy cycles.
    issue(C_PUSH, 8'h0A);
    issue(C_PUSH, 8'h0B);
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_SWAP;
    @(negedge clock);
    bus.cmd = C_PUSH;
    bus.dIn = 8'h77;
    busy = 0;
    while (!bus.cmd_ready && busy < 10) begin
      busy++;
      @(negedge clock);
    end
    bus.cmd_valid = 1'b0;
    chk("swap.busy_cycles", 32'(busy), 32'd4);
    model_apply(C_SWAP, 8'h00);
    check_state("swap");
    chk("swap.top", 32'(bus.dOut), 32'h0A);
    issue(C_POP, 8'h00);
    check_state("swap_pop");
    chk("swap.below", 32'(bus.dOut), 32'h0B);
    issue(C_CLEAR, 8'h00);

    // Random commands against the model.
    for (int i = 0; i < 400; i++) begin
      c = 3'($urandom_range(0, 7));
      if (c == C_CLEAR && $urandom_range(0, 4) != 0) c = C_PUSH;
      d = 8'($urandom);
      issue(c, d);
      check_state($sformatf("rnd%0d", i));
    end

    // Reset asserted mid-ADD during POPA.
    issue(C_CLEAR, 8'h00);
    issue(C_POP, 8'h00);
    issue(C_PUSH, 8'h11);
    issue(C_PUSH, 8'h22);
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_ADD;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    chk("mid.debug_popa", 32'(bus.debug), 32'd2);
    chk("mid.GPO_pre",    32'(bus.GPO),   32'h20);
    #2 reset = 1'b1;
    #1;
    chk("mid.dOut",   32'(bus.dOut),      32'h0);
    chk("mid.dValid", 32'(bus.dValid),    32'h0);
    chk("mid.sp",     32'(bus.sp),        32'h0);
    chk("mid.GPO",    32'(bus.GPO),       32'h0);
    chk("mid.debug",  32'(bus.debug),     32'h0);
    chk("mid.ready",  32'(bus.cmd_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    stk.delete();
    m_gpo = 6'd0;
    @(negedge clock);
    check_state("post_rst");
    issue(C_PUSH, 8'h33);
    check_state("post_rst_push");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rpn_stack_ctrl.md
RPN_STACK_CTRL -- requirements
Module: rpn_stack_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of stack entries, legal range 2..15.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 dIn  input  8  operand pushed by a PUSH command.
REQ-005 cmd_valid  input  1  command request strobe.
REQ-006 cmd  input  3  opcode: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 DUP, 5 SWAP, 6 CLEAR, 7 NOP.
REQ-007 cmd_ready  output  1  high when a command can be accepted.
REQ-008 dOut  output  8  current top-of-stack value.
REQ-009 dValid  output  1  high when the stack is non-empty.
REQ-010 GPO  output  6  status flags: [0] zero, [1] neg, [2] carry/borrow, [3] saturated, [4] overflow error (sticky), [5] underflow error (sticky).
REQ-011 debug  output  4  FSM state code.
REQ-012 sp  output  4  stack depth, range 0..DEPTH.

Function
REQ-013 Handshake: a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1; commands presented while cmd_ready=0 are ignored, not queued.
REQ-014 cmd_ready SHALL equal (state==IDLE).
REQ-015 FSM states and debug codes: IDLE=0, POPB=1, POPA=2, EXEC=3, PUSH2=4.
REQ-016 Single-cycle commands (PUSH, POP, DUP, CLEAR, NOP) SHALL complete on the accepting edge; FSM stays in IDLE.
REQ-017 PUSH: writes dIn to the top, sp+1.
- POP: discards the top, sp-1.
- DUP: copies the top, sp+1.
- CLEAR: sp=0 and clears GPO[5:0].
- NOP: no state change.
REQ-018 Multi-cycle commands (ADD, SUB, SWAP) SHALL sequence IDLE->POPB->POPA->EXEC->IDLE, with PUSH2 inserted between EXEC and IDLE for SWAP.
- POPB latches the top into B, sp-1.
- POPA latches the top into A, sp-1.
REQ-019 EXEC actions:
- ADD pushes A+B.
- SUB pushes A-B, where B was the top.
- SWAP pushes B in EXEC, then A in PUSH2.
REQ-020 Latency from the accepting edge N:
- ADD/SUB: result visible on dOut after edge N+3; cmd_ready high after edge N+3.
- SWAP: result visible after edge N+4; cmd_ready high after edge N+4.
REQ-021 Underflow check at acceptance:
- ADD/SUB/SWAP with sp<2, or POP/DUP with sp=0, SHALL leave the stack unchanged, set GPO[5], and stay in IDLE.
REQ-022 Overflow check at acceptance: PUSH/DUP with sp=DEPTH SHALL leave the stack unchanged, set GPO[4], and stay in IDLE.
REQ-023 GPO[4] and GPO[5] SHALL remain set until CLEAR or reset.
REQ-024 On each ADD/SUB EXEC:
- GPO[0] = (result==0).
- GPO[1] = result[7].
- GPO[2] = unsigned carry-out (ADD) or unsigned borrow A<B (SUB).
REQ-025 GPO[0..2] SHALL be unchanged by other commands, except CLEAR.
REQ-026 dOut SHALL be registered; it equals the top entry when sp>0 and 8'd0 when sp=0.
REQ-027 dValid SHALL be registered and equal (sp!=0).
REQ-028 Intermediate stack depth is visible on sp during POPB/POPA.

Reset
REQ-029 Assertion of reset SHALL immediately force the following, mid-operation included, and abandon any in-flight command:
- state=IDLE, sp=0, dOut=0, dValid=0, GPO=0, debug=0, A=B=0.
REQ-030 cmd_ready SHALL be 1 from the first edge after reset deassertion; stack entry contents need not be cleared.

Configuration
REQ-031 Macro SATURATE_EN:
- Defined: ADD/SUB are signed 8-bit and clamp to 8'h7F / 8'h80 on signed overflow; GPO[3] is set on the EXEC that clamped and cleared on any non-clamping ADD/SUB.
- Undefined: results wrap modulo 256 and GPO[3] is constant 0.
- GPO[2] behaviour is identical in both builds.

Verification
REQ-032 Reset, then PUSH 8'h05 -> dOut=05, dValid=1, sp=1, cmd_ready stays 1.
REQ-033 PUSH 05, PUSH 03, SUB -> cmd_ready low for 3 cycles; dOut=02, sp=1, GPO[2]=0, debug sequence 1,2,3,0.
REQ-034 PUSH 03, PUSH 05, SUB -> dOut=FE, GPO[1]=1, GPO[2]=1.
REQ-035 PUSH 7F, PUSH 01, ADD:
- SATURATE_EN defined -> dOut=7F, GPO[3]=1.
- SATURATE_EN undefined -> dOut=80, GPO[3]=0.
REQ-036 DEPTH+1 PUSHes, then ADD on an empty stack after CLEAR:
- Extra PUSH -> GPO[4]=1, sp=DEPTH.
- After CLEAR, ADD -> GPO[5]=1, sp=0.
REQ-037 PUSH 0A, PUSH 0B, SWAP, with cmd_valid held high during the busy cycles:
- Stack ends as 0B below 0A.
- Busy-cycle commands are ignored.
- Reset asserted during POPA -> all outputs 0 immediately.
